// File: rtl/piece_if.sv
// Bundle between the game sequencer and its surroundings:
// key pulses, random source, playfield RAM enables/status and the piece outputs.
interface piece_if;
    logic       start;
    logic       key_l;
    logic       key_r;
    logic       key_u;
    logic       key_d;
    logic       key_b;
    logic [2:0] rnd;
    logic       el;
    logic       er;
    logic       eu;
    logic       edrop;
    logic       overflow;
    logic       refresh_done;
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] ptype;
    logic [1:0] dir;
    logic       refresh;
    logic       boom;
    logic       game_over;
    logic       busy;

    modport slave (
        input  start, key_l, key_r, key_u, key_d, key_b, rnd,
        input  el, er, eu, edrop, overflow, refresh_done,
        output x, y, ptype, dir, refresh, boom, game_over, busy
    );

    modport master (
        output start, key_l, key_r, key_u, key_d, key_b, rnd,
        output el, er, eu, edrop, overflow, refresh_done,
        input  x, y, ptype, dir, refresh, boom, game_over, busy
    );
endinterface

// File: rtl/piece_ctrl.sv
// Falling-piece game sequencer: spawn, user moves, gravity timing,
// lock/clear handshake with the playfield RAM and game-over detection.
module piece_ctrl #(
    parameter int DROP_TICKS = 50_000_000,
    parameter int SPAWN_X    = 3,
    parameter int SPAWN_Y    = 0
) (
    input  logic clk,
    input  logic rstn,
    piece_if.slave bus
);

    localparam int TW = $clog2(DROP_TICKS);
    localparam logic [TW-1:0] TMAX = TW'(DROP_TICKS - 1);
    localparam logic [4:0] SX = 5'(SPAWN_X);
    localparam logic [4:0] SY = 5'(SPAWN_Y);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_CLEAR,
        S_OVER
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [4:0]    r_x, w_x_nxt;
    logic [4:0]    r_y, w_y_nxt;
    logic [2:0]    r_type, w_type_nxt;
    logic [1:0]    r_dir, w_dir_nxt;
    logic          r_refresh, w_refresh_nxt;
    logic          r_boom, w_boom_nxt;
    logic          r_over, w_over_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_step;

    // Next state and next register values; one action per FALL cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_type_nxt    = r_type;
        w_dir_nxt     = r_dir;
        w_refresh_nxt = 1'b0;
        w_boom_nxt    = 1'b0;
        w_step        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_SPAWN;
            end
            S_SPAWN: begin
                w_type_nxt  = (bus.rnd == 3'd0) ? 3'd1 : bus.rnd;
                w_x_nxt     = SX;
                w_y_nxt     = SY;
                w_dir_nxt   = 2'd0;
                w_timer_nxt = '0;
                w_state_nxt = S_FALL;
            end
            S_FALL: begin
                w_step      = (r_timer == TMAX) || bus.key_d;
                w_timer_nxt = r_timer + 1'b1;
                if (w_step) begin
                    w_timer_nxt = '0;
                    if (bus.edrop) w_y_nxt = r_y + 5'd1;
                    else           w_state_nxt = S_LOCK;
                end else if (bus.key_u) begin
                    if (bus.eu) w_dir_nxt = r_dir + 2'd1;
                end else if (bus.key_l) begin
                    if (bus.el) w_x_nxt = r_x - 5'd1;
                end else if (bus.key_r) begin
                    if (bus.er) w_x_nxt = r_x + 5'd1;
                end else if (bus.key_b) begin
                    w_boom_nxt = 1'b1;
                end
            end
            S_LOCK: begin
                if (bus.overflow) begin
                    w_state_nxt = S_OVER;
                end else begin
                    w_refresh_nxt = 1'b1;
                    w_state_nxt   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (bus.refresh_done) w_state_nxt = S_SPAWN;
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_LOCK) || (w_state_nxt == S_CLEAR);
        w_over_nxt = (w_state_nxt == S_OVER);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_x       <= SX;
            r_y       <= SY;
            r_type    <= 3'd1;
            r_dir     <= 2'd0;
            r_refresh <= 1'b0;
            r_boom    <= 1'b0;
            r_over    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_type    <= w_type_nxt;
            r_dir     <= w_dir_nxt;
            r_refresh <= w_refresh_nxt;
            r_boom    <= w_boom_nxt;
            r_over    <= w_over_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.ptype     = r_type;
    assign bus.dir       = r_dir;
    assign bus.refresh   = r_refresh;
    assign bus.boom      = r_boom;
    assign bus.game_over = r_over;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed vector bench for piece_ctrl with DROP_TICKS=4, SPAWN_X=3, SPAWN_Y=0.
// Each record is one clock cycle of inputs plus the outputs expected after it.
module tb_piece_ctrl;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    piece_if u_if();

    piece_ctrl #(
        .DROP_TICKS (4),
        .SPAWN_X    (3),
        .SPAWN_Y    (0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if)
    );

    // keys {start,l,r,u,d,b}; en {el,er,eu,edrop}; flags {refresh,boom,game_over,busy}
    typedef struct {
        logic [5:0] k;
        logic [2:0] rnd;
        logic [3:0] en;
        logic       ovf;
        logic       rd;
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] t;
        logic [1:0] d;
        logic [3:0] f;
    } vec_t;

    localparam logic [5:0] K0  = 6'b000000;
    localparam logic [5:0] K_S = 6'b100000;
    localparam logic [5:0] K_L = 6'b010000;
    localparam logic [5:0] K_R = 6'b001000;
    localparam logic [5:0] K_U = 6'b000100;
    localparam logic [5:0] K_D = 6'b000010;
    localparam logic [5:0] K_B = 6'b000001;
    localparam logic [3:0] EA  = 4'b1111;
    localparam logic [3:0] F0  = 4'b0000;
    localparam logic [3:0] F_R = 4'b1000;
    localparam logic [3:0] F_B = 4'b0100;
    localparam logic [3:0] F_G = 4'b0010;
    localparam logic [3:0] F_Y = 4'b0001;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tab[$];

    function automatic vec_t mk(
        input logic [5:0] k, input logic [2:0] rnd, input logic [3:0] en,
        input logic ovf, input logic rd,
        input logic [4:0] x, input logic [4:0] y, input logic [2:0] t,
        input logic [1:0] d, input logic [3:0] f);
        vec_t v;
        v.k = k; v.rnd = rnd; v.en = en; v.ovf = ovf; v.rd = rd;
        v.x = x; v.y = y; v.t = t; v.d = d; v.f = f;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [3:0] got_f;
        {u_if.start, u_if.key_l, u_if.key_r,
         u_if.key_u, u_if.key_d, u_if.key_b} = v.k;
        u_if.rnd = v.rnd;
        {u_if.el, u_if.er, u_if.eu, u_if.edrop} = v.en;
        u_if.overflow = v.ovf;
        u_if.refresh_done = v.rd;
        @(posedge clk);
        #1;
        got_f = {u_if.refresh, u_if.boom, u_if.game_over, u_if.busy};
        n_vec++;
        if (u_if.x !== v.x || u_if.y !== v.y || u_if.ptype !== v.t ||
            u_if.dir !== v.d || got_f !== v.f) begin
            n_bad++;
            $display("FAIL vec%0d: got x=%0d y=%0d type=%0d dir=%0d flags=%b, exp x=%0d y=%0d type=%0d dir=%0d flags=%b",
                     n_vec - 1, u_if.x, u_if.y, u_if.ptype, u_if.dir, got_f,
                     v.x, v.y, v.t, v.d, v.f);
        end
    endtask

    initial begin
        rstn = 1'b0;
        {u_if.start, u_if.key_l, u_if.key_r, u_if.key_u, u_if.key_d, u_if.key_b} = '0;
        u_if.rnd = '0;
        {u_if.el, u_if.er, u_if.eu, u_if.edrop} = '0;
        u_if.overflow = 1'b0;
        u_if.refresh_done = 1'b0;

        // spawn, gravity, moves, priorities, lock/clear, respawn
        tab.push_back(mk(K_S,       0, EA,      0, 0, 3, 0, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 1, 1, 0, F0));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 1, 1, 1, F0));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 1, 1, 2, F0));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 1, 1, 3, F0));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 2, 1, 3, F0));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 2, 1, 0, F0));
        tab.push_back(mk(K_L,       0, 4'b0111, 0, 0, 3, 2, 1, 0, F0));
        tab.push_back(mk(K_L,       0, EA,      0, 0, 2, 2, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 2, 3, 1, 0, F0));
        tab.push_back(mk(K_R,       0, EA,      0, 0, 3, 3, 1, 0, F0));
        tab.push_back(mk(K_D | K_L, 0, EA,      0, 0, 3, 4, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 4, 1, 0, F0));
        tab.push_back(mk(K_B,       0, EA,      0, 0, 3, 4, 1, 0, F_B));
        tab.push_back(mk(K_L | K_R, 0, EA,      0, 0, 2, 4, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 2, 5, 1, 0, F0));
        tab.push_back(mk(K_U,       0, 4'b1101, 0, 0, 2, 5, 1, 0, F0));
        tab.push_back(mk(K_B | K_R, 0, EA,      0, 0, 3, 5, 1, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 1, 3, 5, 1, 0, F0));
        tab.push_back(mk(K0,        0, 4'b1110, 0, 0, 3, 5, 1, 0, F_Y));
        tab.push_back(mk(K_L,       0, EA,      0, 0, 3, 5, 1, 0, F_R | F_Y));
        tab.push_back(mk(K_D | K_L, 0, EA,      0, 0, 3, 5, 1, 0, F_Y));
        tab.push_back(mk(K_U,       0, EA,      0, 0, 3, 5, 1, 0, F_Y));
        tab.push_back(mk(K_B,       0, EA,      0, 0, 3, 5, 1, 0, F_Y));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 5, 1, 0, F_Y));
        tab.push_back(mk(K0,        5, EA,      0, 1, 3, 5, 1, 0, F0));
        tab.push_back(mk(K0,        5, EA,      0, 0, 3, 0, 5, 0, F0));
        tab.push_back(mk(K_D,       0, EA,      0, 0, 3, 1, 5, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 1, 5, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 1, 5, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 1, 5, 0, F0));
        tab.push_back(mk(K0,        0, EA,      0, 0, 3, 2, 5, 0, F0));

        // reset state over two reset cycles
        apply(mk(K_S | K_D, 6, EA, 0, 1, 3, 0, 1, 0, F0));
        apply(mk(K_S,       6, EA, 0, 1, 3, 0, 1, 0, F0));
        rstn = 1'b1;

        foreach (tab[i]) apply(tab[i]);

        // landing with overflow: game over, outputs frozen
        apply(mk(K_D,       0, 4'b1110, 0, 0, 3, 2, 5, 0, F_Y));
        apply(mk(K0,        0, EA,      1, 0, 3, 2, 5, 0, F_G));
        apply(mk(K_S | K_L, 7, EA,      1, 1, 3, 2, 5, 0, F_G));
        apply(mk(K_D,       7, EA,      0, 0, 3, 2, 5, 0, F_G));
        for (int i = 0; i < 3; i++)
            apply(mk(K_S, 7, EA, 0, 1, 3, 2, 5, 0, F_G));
        rstn = 1'b0;
        apply(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        rstn = 1'b1;

        // reset in the middle of CLEAR aborts to IDLE
        apply(mk(K_S,       2, EA,      0, 0, 3, 0, 1, 0, F0));
        apply(mk(K0,        2, EA,      0, 0, 3, 0, 2, 0, F0));
        apply(mk(K_D,       0, 4'b1110, 0, 0, 3, 0, 2, 0, F_Y));
        apply(mk(K0,        0, EA,      0, 0, 3, 0, 2, 0, F_R | F_Y));
        apply(mk(K0,        0, EA,      0, 0, 3, 0, 2, 0, F_Y));
        rstn = 1'b0;
        apply(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        rstn = 1'b1;
        apply(mk(K0,        4, EA,      0, 1, 3, 0, 1, 0, F0));
        apply(mk(K0,        4, EA,      0, 0, 3, 0, 1, 0, F0));
        apply(mk(K_S,       0, EA,      0, 0, 3, 0, 1, 0, F0));
        apply(mk(K0,        0, EA,      0, 0, 3, 0, 1, 0, F0));
        apply(mk(K_R,       0, EA,      0, 0, 4, 0, 1, 0, F0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
